ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-clock arbiter that shares the write port and the read port of the team's dual-port RAM (`DUAL_RAM`) among `NUM_REQ` clients. Each port has its own independent round-robin arbiter. The read side tracks the RAM's one-cycle registered read latency and returns data to the granted client with a one-hot valid. It sits between the client logic and `DUAL_RAM`, with both RAM clocks tied to `clk`.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: RAM word width.
- `ADDR_WIDTH`, default 4: RAM address width.
- `NUM_REQ`, default 2: number of clients, range 2..8.

**Ports**
- `clk`  in  1: the single clock; also drives the RAM.
- `rst`  in  1: reset, synchronous and active-high.
- `wreq`  in  NUM_REQ: per-client write request.
- `wr_addr`  in  NUM_REQ*ADDR_WIDTH: per-client write address; client k occupies slice k.
- `wr_data`  in  NUM_REQ*DATA_WIDTH: per-client write data; client k occupies slice k.
- `wgnt`  out  NUM_REQ: one-hot write grant.
- `rreq`  in  NUM_REQ: per-client read request.
- `rd_addr`  in  NUM_REQ*ADDR_WIDTH: per-client read address; client k occupies slice k.
- `rgnt`  out  NUM_REQ: one-hot read grant.
- `rvalid`  out  NUM_REQ: one-hot flag marking which client owns `rd_data` this cycle.
- `rd_data`  out  DATA_WIDTH: read data, broadcast to all clients.
- `ram_wclken`  out  1: to RAM `wclken`.
- `ram_waddr`  out  ADDR_WIDTH: to RAM `waddr`.
- `ram_wdata`  out  DATA_WIDTH: to RAM `wrdata`.
- `ram_raddr`  out  ADDR_WIDTH: to RAM `raddr`.
- `ram_rdata`  in  DATA_WIDTH: from RAM `rdata`.

## Operation

**Handshake**
- A client holds `req` and its address/data stable until it sees `gnt` high.
- A transfer completes on the rising edge where `req` and `gnt` are both high.
- A client may drop `req` without being granted; nothing happens.

**Arbitration** (the write and read arbiters are identical and independent)
- Each arbiter keeps a priority pointer `p` in 0..NUM_REQ-1, reset to 0.
- Grant goes to the first asserted request found scanning indices `p, p+1, …` modulo NUM_REQ.
- The grant is combinational from the current `req` and `p`, and is one-hot or zero.
- After a grant to client k, `p` becomes `(k+1) mod NUM_REQ`.
- With no request, `p` holds.
- A client with `req` held continuously is granted within NUM_REQ cycles (no starvation).

**RAM drive**
- `ram_wclken` = OR of `wgnt`.
- `ram_waddr` / `ram_wdata` = slice of the granted writer; all zeros when there is no grant.
- `ram_raddr` = slice of the granted reader; holds its last value when there is no read grant.

**Read return**
- A one-hot register `rtag` captures `rgnt` every cycle.
- `rvalid` = `rtag`.
- `rd_data` = `ram_rdata` when `rtag` is non-zero; 0 otherwise.

**Same-cycle read/write to the same address**
- The read returns the pre-write value, which is the RAM's native behaviour.
- The write takes effect; the following read returns the new value.
- No forwarding.

**Reset**
- `rst` high at an edge clears both pointers and `rtag`.
- While `rst` is high, `wgnt`, `rgnt` and `ram_wclken` are forced to 0, and the pointers do not advance.
- A read granted in the cycle before `rst` rises does not produce `rvalid`.

## Timing

- Reset values: `wgnt`=0, `rgnt`=0, `rvalid`=0, `rd_data`=0, `ram_wclken`=0, `ram_waddr`=0, `ram_wdata`=0, `ram_raddr`=0, both pointers=0, `rtag`=0.
- Write: grant in cycle N; RAM updated at the end of cycle N. Zero added latency.
- Read: grant in cycle N; `rvalid`/`rd_data` in cycle N+1, for exactly one cycle.
- Back-to-back grants are permitted every cycle on each port, giving a throughput of 1 write plus 1 read per cycle.
- The pointer update is registered, so cycle N's grant result determines cycle N+1's priority.
- Combinational paths: `req` → `gnt`, and `req` → `ram_*` address/data. No combinational path from `ram_rdata` to any `gnt`.

## Test plan

- **Reset:** hold `rst` 3 cycles with all `req` high → all outputs 0. First cycle after release: `wgnt`=`rgnt`=0001 (NUM_REQ=4).
- **Round-robin:** NUM_REQ=4, all `wreq` held 8 cycles → `wgnt` sequence 0001,0010,0100,1000,0001,0010,0100,1000. Pointer skips idle clients: with `wreq`=0101 → 0001,0100,0001.
- **Write/read loop:** client 1 writes 0xA5 to addr 3; next cycle client 0 reads addr 3 → `rvalid`=0001 and `rd_data`=0xA5 exactly one cycle after `rgnt`.
- **Collision:** addr 5 holds 0x11; in the same cycle client 0 writes 0x22 to addr 5 and client 1 reads addr 5 → returns 0x11; a repeat read returns 0x22.
- **Reset mid-operation:** read granted in cycle N, `rst` high in cycle N+1 → `rvalid` stays 0; pointers back to 0.
- **Fairness:** `rreq` all high for 100 cycles → each client granted exactly 25 times; no gap longer than 4 cycles for any client.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the write and read ports of a dual-port RAM among NUM_REQ clients
// using two independent round-robin arbiters; read data returns one cycle later.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             wreq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_REQ-1:0]             wgnt,
  input  logic [NUM_REQ-1:0]             rreq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]             rgnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           ram_wclken,
  output logic [ADDR_WIDTH-1:0]          ram_waddr,
  output logic [DATA_WIDTH-1:0]          ram_wdata,
  output logic [ADDR_WIDTH-1:0]          ram_raddr,
  input  logic [DATA_WIDTH-1:0]          ram_rdata
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [NUM_REQ-1:0]    rtag_q, rtag_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] rd_slice;

  // Scan downward from the far end so the surviving pick is the one nearest ptr.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PW-1:0] ptr);
    logic [NUM_REQ-1:0] g;
    logic [PW:0]        sum;
    logic [PW-1:0]      idx;
    g = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [NUM_REQ-1:0] gnt,
                                             input logic [PW-1:0] ptr);
    logic [PW-1:0] n;
    n = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) n = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    wgnt       = rst ? '0 : rr_pick(wreq, wptr_q);
    rgnt       = rst ? '0 : rr_pick(rreq, rptr_q);
    wptr_d     = next_ptr(wgnt, wptr_q);
    rptr_d     = next_ptr(rgnt, rptr_q);
    ram_wclken = |wgnt;
    ram_waddr  = '0;
    ram_wdata  = '0;
    rd_slice   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wgnt[k]) begin
        ram_waddr = ram_waddr | wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = ram_wdata | wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rgnt[k]) rd_slice = rd_slice | rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
    raddr_d   = (|rgnt) ? rd_slice : raddr_q;
    ram_raddr = raddr_d;
    rtag_d    = rgnt;
    // A read in flight when reset arrives must not surface as valid data.
    rvalid    = rst ? '0 : rtag_q;
    rd_data   = (|rvalid) ? ram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rtag_q  <= '0;
      raddr_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rtag_q  <= rtag_d;
      raddr_q <= raddr_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with four clients and a behavioural
// registered-read dual-port RAM attached.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     wreq, rreq;
  logic [NR*AW-1:0]  wr_addr, rd_addr;
  logic [NR*DW-1:0]  wr_data;
  logic [NR-1:0]     wgnt, rgnt, rvalid;
  logic [DW-1:0]     rd_data;
  logic              ram_wclken;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [DW-1:0]     ram_wdata, ram_rdata;
  logic [DW-1:0]     mem [0:(1<<AW)-1];

  int total  = 0;
  int passed = 0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .wreq(wreq), .wr_addr(wr_addr), .wr_data(wr_data), .wgnt(wgnt),
    .rreq(rreq), .rd_addr(rd_addr), .rgnt(rgnt), .rvalid(rvalid), .rd_data(rd_data),
    .ram_wclken(ram_wclken), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM: a same-edge read sees the old contents.
  always @(posedge clk) begin
    if (ram_wclken) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt [NR];
  int last [NR];
  int maxgap [NR];
  int bad_onehot;
  int gap;

  initial begin
    rst = 1'b1;
    wreq = '1; rreq = '1;
    for (int k = 0; k < NR; k++) begin
      wr_addr[k*AW +: AW] = AW'(8 + k);
      wr_data[k*DW +: DW] = DW'(8'h10 + k);
      rd_addr[k*AW +: AW] = AW'(k);
    end

    repeat (3) begin
      tick();
      #1;
      chk("rst_wgnt", 32'(wgnt), 0);
      chk("rst_rgnt", 32'(rgnt), 0);
      chk("rst_wclken", 32'(ram_wclken), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
    end
    chk("rst_waddr", 32'(ram_waddr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_raddr", 32'(ram_raddr), 0);

    // Release reset with every client requesting: strict rotation on both ports.
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin tick(); #1; end
      chk("rr_wgnt", 32'(wgnt), 32'(1 << (i % 4)));
      chk("rr_rgnt", 32'(rgnt), 32'(1 << (i % 4)));
      chk("rr_waddr", 32'(ram_waddr), 32'(8 + (i % 4)));
      chk("rr_wdata", 32'(ram_wdata), 32'(8'h10 + (i % 4)));
      if (i > 0) chk("rr_rvalid", 32'(rvalid), 32'(1 << ((i - 1) % 4)));
    end

    tick();
    wreq = 4'b0101; rreq = '0;
    #1;
    chk("skip_wgnt0", 32'(wgnt), 32'b0001);
    chk("rr_last_rvalid", 32'(rvalid), 32'b1000);
    tick(); #1;
    chk("skip_wgnt1", 32'(wgnt), 32'b0100);
    chk("idle_rvalid", 32'(rvalid), 0);
    tick(); #1;
    chk("skip_wgnt2", 32'(wgnt), 32'b0001);

    // Client 1 writes A5 to address 3, client 0 reads it back.
    tick();
    wreq = 4'b0010;
    wr_addr[1*AW +: AW] = 4'd3;
    wr_data[1*DW +: DW] = 8'hA5;
    #1;
    chk("wr_wgnt", 32'(wgnt), 32'b0010);
    chk("wr_wclken", 32'(ram_wclken), 1);
    chk("wr_waddr", 32'(ram_waddr), 3);
    chk("wr_wdata", 32'(ram_wdata), 32'hA5);
    tick();
    wreq = '0; rreq = 4'b0001;
    rd_addr[0*AW +: AW] = 4'd3;
    #1;
    chk("rd_rgnt", 32'(rgnt), 32'b0001);
    chk("rd_raddr", 32'(ram_raddr), 3);
    chk("idle_wclken", 32'(ram_wclken), 0);
    chk("idle_waddr", 32'(ram_waddr), 0);
    chk("idle_wdata", 32'(ram_wdata), 0);
    tick();
    rreq = '0;
    #1;
    chk("rd_rvalid", 32'(rvalid), 32'b0001);
    chk("rd_data", 32'(rd_data), 32'hA5);
    chk("raddr_hold", 32'(ram_raddr), 3);
    tick(); #1;
    chk("rd_rvalid_once", 32'(rvalid), 0);
    chk("rd_data_zero", 32'(rd_data), 0);

    // Collision: address 5 holds 11, then write 22 and read 5 in one cycle.
    tick();
    wreq = 4'b0001;
    wr_addr[0*AW +: AW] = 4'd5;
    wr_data[0*DW +: DW] = 8'h11;
    #1;
    chk("col_pre_wgnt", 32'(wgnt), 32'b0001);
    tick();
    wr_data[0*DW +: DW] = 8'h22;
    rreq = 4'b0010;
    rd_addr[1*AW +: AW] = 4'd5;
    #1;
    chk("col_wgnt", 32'(wgnt), 32'b0001);
    chk("col_rgnt", 32'(rgnt), 32'b0010);
    chk("col_raddr", 32'(ram_raddr), 5);
    tick();
    wreq = '0; rreq = '0;
    #1;
    chk("col_rvalid", 32'(rvalid), 32'b0010);
    chk("col_old_data", 32'(rd_data), 32'h11);
    tick();
    rreq = 4'b0010;
    #1;
    chk("col_rerd_rgnt", 32'(rgnt), 32'b0010);
    tick();
    rreq = '0;
    #1;
    chk("col_new_data", 32'(rd_data), 32'h22);
    chk("col_new_rvalid", 32'(rvalid), 32'b0010);

    // Reset lands while a read is in flight.
    tick();
    rreq = 4'b0100;
    rd_addr[2*AW +: AW] = 4'd5;
    #1;
    chk("mid_rgnt", 32'(rgnt), 32'b0100);
    tick();
    rst = 1'b1; rreq = '0;
    #1;
    chk("mid_rvalid", 32'(rvalid), 0);
    chk("mid_rd_data", 32'(rd_data), 0);
    tick();
    rst = 1'b0; wreq = '1; rreq = '1;
    #1;
    chk("mid_wptr", 32'(wgnt), 32'b0001);
    chk("mid_rptr", 32'(rgnt), 32'b0001);

    // Fairness over 100 cycles of continuous read requests.
    bad_onehot = 0;
    for (int k = 0; k < NR; k++) begin cnt[k] = 0; last[k] = -1; maxgap[k] = 0; end
    for (int c = 0; c < 100; c++) begin
      if (!$onehot(rgnt)) bad_onehot++;
      for (int k = 0; k < NR; k++) begin
        if (rgnt[k]) begin
          cnt[k]++;
          gap = c - last[k];
          if (gap > maxgap[k]) maxgap[k] = gap;
          last[k] = c;
        end
      end
      tick();
      wreq = '0;
      #1;
    end
    rreq = '0;
    for (int k = 0; k < NR; k++) begin
      gap = 100 - last[k];
      if (gap > maxgap[k]) maxgap[k] = gap;
      chk($sformatf("fair_cnt%0d", k), 32'(cnt[k]), 25);
      chk($sformatf("fair_gap%0d", k), 32'(maxgap[k]), 4);
    end
    chk("fair_onehot", 32'(bad_onehot), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
